// File: rtl/stream_mux_nx1_if.sv
// stream_mux_nx1_if: handshake bundle between N input channels and the single
// muxed output of stream_mux_nx1. The slave modport is the mux's view; master
// is the environment (sources + sink) driving it.
interface stream_mux_nx1_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
);
  localparam int unsigned CH_W = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [CH_W-1:0]    out_ch;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-to-1 valid/ready stream multiplexer with a single output
// register stage (one-cycle latency, one beat per cycle).
// Optional macro STREAM_MUX_RR_EN selects round-robin arbitration; when it is
// undefined the arbiter is fixed priority (lowest valid index wins) and no
// pointer state exists.
module stream_mux_nx1 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_mux_nx1_if.slave  bus
);

  localparam int unsigned CH_W = $clog2(N);

  logic             can_load;
  logic             any_valid;
  logic             in_xfer;
  logic [N-1:0]     grant_oh;
  logic [CH_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;

`ifdef STREAM_MUX_RR_EN
  logic [CH_W-1:0]  rr_ptr;

  // Round-robin search starting at rr_ptr, wrapping N-1 -> 0.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_valid && bus.in_valid[CH_W'(idx)]) begin
        any_valid              = 1'b1;
        grant_idx              = CH_W'(idx);
        grant_oh[CH_W'(idx)]   = 1'b1;
      end
    end
  end

  // Pointer advances past the channel that just transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer) begin
      rr_ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + CH_W'(1);
    end
  end
`else
  // Fixed priority: lowest-indexed valid channel wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_valid && bus.in_valid[CH_W'(i)]) begin
        any_valid          = 1'b1;
        grant_idx          = CH_W'(i);
        grant_oh[CH_W'(i)] = 1'b1;
      end
    end
  end
`endif

  // Select the granted channel's data; one-hot so at most one match.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_oh[CH_W'(i)]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready depends only on valids and output state, never on data; held low in reset.
  always_comb begin
    can_load     = !out_valid_q || bus.out_ready;
    in_xfer      = rst_n && can_load && any_valid;
    bus.in_ready = (rst_n && can_load) ? grant_oh : '0;
  end

  // Output register: load on input transfer, empty on a pure output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_ch_q    <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: directed self-checking bench for stream_mux_nx1 at
// WIDTH=64, N=4. Arbitration expectations follow STREAM_MUX_RR_EN.
module tb_stream_mux_nx1;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned N     = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  stream_mux_nx1_if #(.WIDTH(WIDTH), .N(N)) bus ();

  stream_mux_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    bus.in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got=%0d exp=0", bus.out_ch); end
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    bus.in_valid = 4'b0000;
    rst_n        = 1'b1;
    tick();
  endtask

  task automatic test_single_and_throughput();
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    set_ch(0, 64'd11);
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL single_in_ready got=%b exp=0001", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0d exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd11) begin errors++; $display("FAIL single_out_data got=%0d exp=11", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL single_out_ch got=%0d exp=0", bus.out_ch); end
    for (int k = 0; k < 8; k++) begin
      set_ch(0, 64'(100 + k));
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL thru_valid beat=%0d got=%0d exp=1", k, bus.out_valid); end
      checks++; if (bus.out_data !== 64'(100 + k)) begin errors++; $display("FAIL thru_data beat=%0d got=%0d exp=%0d", k, bus.out_data, 100 + k); end
    end
    bus.in_valid = 4'b0000;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd107) begin errors++; $display("FAIL drain_hold_data got=%0d exp=107", bus.out_data); end
  endtask

  task automatic test_backpressure();
    logic [3:0]       exp_ready;
    logic [1:0]       exp_ch;
    logic [WIDTH-1:0] exp_data;
`ifdef STREAM_MUX_RR_EN
    exp_ready = 4'b0100; exp_ch = 2'd2; exp_data = 64'd72;
`else
    exp_ready = 4'b0001; exp_ch = 2'd0; exp_data = 64'd70;
`endif
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    set_ch(1, 64'd22);
    tick();
    checks++; if (bus.out_data !== 64'd22 || bus.out_ch !== 2'd1) begin errors++; $display("FAIL bp_load got=%0d/ch%0d exp=22/ch1", bus.out_data, bus.out_ch); end
    bus.in_valid = 4'b1111;
    set_ch(0, 64'd70); set_ch(1, 64'd71); set_ch(2, 64'd72); set_ch(3, 64'd73);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0000", c, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd22 || bus.out_ch !== 2'd1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=v%0d/%0d/ch%0d exp=v1/22/ch1", c, bus.out_valid, bus.out_data, bus.out_ch);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL bp_release_ready got=%b exp=%b", bus.in_ready, exp_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data || bus.out_ch !== exp_ch) begin
      errors++; $display("FAIL bp_release_load got=v%0d/%0d/ch%0d exp=v1/%0d/ch%0d", bus.out_valid, bus.out_data, bus.out_ch, exp_data, exp_ch);
    end
    bus.in_valid = 4'b0000;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", bus.out_valid); end
  endtask

`ifdef STREAM_MUX_RR_EN
  task automatic test_round_robin();
    rst_n = 1'b0;
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 64'(33 + i));
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.out_ch !== 2'(k % 4) || bus.out_data !== 64'(33 + (k % 4))) begin
        errors++; $display("FAIL rr_seq k=%0d got=%0d/ch%0d exp=%0d/ch%0d", k, bus.out_data, bus.out_ch, 33 + (k % 4), k % 4);
      end
    end
    bus.in_valid = 4'b0100;
    set_ch(2, 64'd60);
    tick();
    checks++; if (bus.out_ch !== 2'd2 || bus.out_data !== 64'd60) begin errors++; $display("FAIL rr_setptr got=%0d/ch%0d exp=60/ch2", bus.out_data, bus.out_ch); end
    bus.in_valid = 4'b0101;
    set_ch(0, 64'd55); set_ch(2, 64'd66);
    tick();
    checks++; if (bus.out_ch !== 2'd0 || bus.out_data !== 64'd55) begin errors++; $display("FAIL rr_wrap0 got=%0d/ch%0d exp=55/ch0", bus.out_data, bus.out_ch); end
    tick();
    checks++; if (bus.out_ch !== 2'd2 || bus.out_data !== 64'd66) begin errors++; $display("FAIL rr_wrap2 got=%0d/ch%0d exp=66/ch2", bus.out_data, bus.out_ch); end
    bus.in_valid = 4'b1111;
    set_ch(1, 64'd88); set_ch(3, 64'd99);
    tick();
    checks++; if (bus.out_ch !== 2'd3 || bus.out_data !== 64'd99) begin errors++; $display("FAIL rr_ptr_end got=%0d/ch%0d exp=99/ch3", bus.out_data, bus.out_ch); end
    bus.in_valid = 4'b0000;
    tick();
  endtask
`else
  task automatic test_fixed_priority();
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1110;
    set_ch(1, 64'd44); set_ch(2, 64'd45); set_ch(3, 64'd46);
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL fp_in_ready got=%b exp=0010", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.out_ch !== 2'd1 || bus.out_data !== 64'd44) begin
        errors++; $display("FAIL fp_ch1 k=%0d got=%0d/ch%0d exp=44/ch1", k, bus.out_data, bus.out_ch);
      end
    end
    bus.in_valid = 4'b1100;
    tick();
    checks++; if (bus.out_ch !== 2'd2 || bus.out_data !== 64'd45) begin errors++; $display("FAIL fp_ch2 got=%0d/ch%0d exp=45/ch2", bus.out_data, bus.out_ch); end
    bus.in_valid = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_async_reset();
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    set_ch(1, 64'd12);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'd12) begin errors++; $display("FAIL ar_pre got=v%0d/%0d exp=v1/12", bus.out_valid, bus.out_data); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 64'd0) begin errors++; $display("FAIL ar_data got=%0d exp=0", bus.out_data); end
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b1;
    set_ch(3, 64'd77);
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL ar_in_ready got=%b exp=0000", bus.in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== 64'd77) begin
      errors++; $display("FAIL ar_after got=v%0d/%0d/ch%0d exp=v1/77/ch3", bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_and_throughput();
    test_backpressure();
`ifdef STREAM_MUX_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_nx1.md
STREAM_MUX_NX1 -- requirements
Module: stream_mux_nx1

Interface
REQ-001 Parameter WIDTH, default 64, data width of every channel in bits.
REQ-002 Parameter N, default 4, number of input channels (legal 2..16).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  N  per-channel valid; bit i belongs to channel i.
REQ-006 in_data  input  N*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  N  per-channel ready; combinational.
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  WIDTH  registered data of held beat.
REQ-010 out_ch  output  $clog2(N)  index of channel that supplied held beat.
REQ-011 out_ready  input  1  downstream accepts held beat this cycle.

Function
REQ-012 Transfer on channel i SHALL occur in a cycle when in_valid[i] and in_ready[i] are both 1.
REQ-013 Output transfer SHALL occur in a cycle when out_valid and out_ready are both 1.
REQ-014 Block SHALL be able to load when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (full throughput, one beat per cycle).
REQ-015 Exactly one channel SHALL be granted per cycle, selected only among channels with in_valid=1; in_ready[i]=1 only for granted channel i, and only while able to load.
REQ-016 If no in_valid bit is set, all in_ready bits SHALL be 0.
REQ-017 On an input transfer, out_data SHALL take the granted channel's data, out_ch its index, and out_valid SHALL be 1 on the next edge; latency input-to-output is one cycle.
REQ-018 On an output transfer with no simultaneous input transfer, out_valid SHALL go 0 on the next edge; out_data and out_ch SHALL hold their values.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL be held stable and in_ready SHALL be all 0.
REQ-020 in_ready SHALL NOT depend combinationally on in_data.
REQ-021 Input channel data SHALL never be dropped or duplicated: each input transfer yields exactly one output transfer, in grant order.

Reset
REQ-022 While rst_n=0: out_valid=0, out_data=0, out_ch=0, round-robin pointer=0, independent of clk.
REQ-023 Reset asserted mid-transfer SHALL discard the held beat; first grant after release follows REQ-022 state.
REQ-024 in_ready SHALL be all 0 while rst_n=0.

Configuration
REQ-025 Macro STREAM_MUX_RR_EN defined: grant SHALL be round-robin; search starts at pointer P, wraps N-1 to 0; after an input transfer from channel g, P SHALL become (g+1) mod N; P unchanged on cycles with no input transfer.
REQ-026 Macro STREAM_MUX_RR_EN undefined: grant SHALL be fixed priority, lowest valid index wins; no pointer state is implemented.

Verification (WIDTH=64, N=4)
REQ-027 Reset, then in_valid=0001, in_data ch0=11, out_ready=1 -> next cycle out_valid=1, out_data=11, out_ch=0; throughput 1 beat/cycle over 8 consecutive beats.
REQ-028 out_valid=1 holding 22 from ch1, out_ready=0 for 3 cycles, in_valid=1111 -> in_ready=0000, out_data=22 stable; out_ready=1 -> beat consumed, next beat loaded same cycle.
REQ-029 RR_EN defined, in_valid=1111 constant, out_ready=1, ch i data=33+i -> out_ch sequence 0,1,2,3,0; out_data 33,34,35,36,33.
REQ-030 RR_EN undefined, in_valid=1110 constant -> out_ch always 1, data of ch1 (44); drop ch1 valid -> out_ch 2.
REQ-031 RR_EN defined, pointer=3, in_valid=0101 -> wrap grants ch0 (55) then ch2 (66), pointer ends at 3.
REQ-032 rst_n pulled low asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0 immediately; after release, in_valid=1000 -> out_ch=3 next cycle.
